// File: rtl/membus_pkg.sv
// membus_pkg: shared encodings for the memory bus arbiter
// (request codes, FSM states, err_o bit positions).
package membus_pkg;
    typedef enum logic [1:0] {IO_IDLE = 2'b00, IO_RD = 2'b01, IO_WT = 2'b10} iostate_t;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    localparam int ERR_OOR = 0;
    localparam int ERR_ILL = 1;
    localparam int ERR_CHG = 2;
    localparam int ERR_RSV = 3;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port DATA_W x WORDS store, synchronous write and registered read.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int WORDS  = 65536,
    parameter int AW     = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [WORDS];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: round-robin arbiter giving N cache ports fixed-latency access to one word memory.
// Defining MEMBUS_ERR_EN adds the sticky err_o status port and out-of-range suppression.
module mem_bus_arb
    import membus_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 65536,
    parameter int LATENCY   = 100
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2*N_PORTS-1:0]      rw_i,
    input  logic [ADDR_W*N_PORTS-1:0] addr_i,
    input  logic [DATA_W*N_PORTS-1:0] wdata_i,
    output logic [DATA_W*N_PORTS-1:0] rdata_o,
    output logic [N_PORTS-1:0]        ack_o,
    output logic [N_PORTS-1:0]        gnt_o,
`ifdef MEMBUS_ERR_EN
    output logic [3:0]                err_o,
`endif
    output logic                      busy_o
);
    localparam int MA_W = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
    localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic [PW-1:0]     ptr, sel, own;
    logic [N_PORTS-1:0] req;
    logic [1:0]        lat_rw;
    logic [ADDR_W-1:0] lat_addr, sel_addr;
    logic [DATA_W-1:0] lat_wdata, q;
    logic [MA_W-1:0]   idx;
    logic              oor, oor_in, we;

    always_comb
        for (int p = 0; p < N_PORTS; p++)
            req[p] = rw_i[2*p +: 2] == IO_RD || rw_i[2*p +: 2] == IO_WT;

    // Scan downward so the port nearest the pointer is assigned last and wins.
    always_comb begin
        sel = '0;
        for (int i = N_PORTS - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N_PORTS]) sel = PW'((int'(ptr) + i) % N_PORTS);
    end

    assign sel_addr = addr_i[ADDR_W*sel +: ADDR_W];
`ifdef MEMBUS_ERR_EN
    assign oor_in = {1'b0, sel_addr} >= (ADDR_W+1)'(MEM_WORDS);
`else
    assign oor_in = 1'b0;
`endif
    assign idx = MA_W'(32'(lat_addr) % MEM_WORDS);
    assign we  = state == S_BUSY && cnt == '0 && lat_rw == IO_WT && !oor;

    mem_array #(.DATA_W(DATA_W), .WORDS(MEM_WORDS), .AW(MA_W)) u_mem (
        .clk   (clk),
        .we    (we),
        .addr  (idx),
        .wdata (lat_wdata),
        .rdata (q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ptr       <= '0;
            own       <= '0;
            lat_rw    <= IO_IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            oor       <= 1'b0;
            ack_o     <= '0;
            gnt_o     <= '0;
            busy_o    <= 1'b0;
            rdata_o   <= '0;
        end else begin
            ack_o <= '0;
            case (state)
                S_IDLE: if (|req) begin
                    state     <= S_BUSY;
                    cnt       <= CNT_INIT;
                    own       <= sel;
                    ptr       <= int'(sel) == N_PORTS - 1 ? '0 : sel + 1'b1;
                    lat_rw    <= rw_i[2*sel +: 2];
                    lat_addr  <= sel_addr;
                    lat_wdata <= wdata_i[DATA_W*sel +: DATA_W];
                    oor       <= oor_in;
                    gnt_o     <= N_PORTS'(1) << sel;
                    busy_o    <= 1'b1;
                end
                S_BUSY: if (cnt == '0) state <= S_DONE; else cnt <= cnt - 1'b1;
                S_DONE: begin
                    state      <= S_IDLE;
                    ack_o[own] <= 1'b1;
                    gnt_o      <= '0;
                    busy_o     <= 1'b0;
                    if (lat_rw == IO_RD) rdata_o[DATA_W*own +: DATA_W] <= oor ? '0 : q;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEMBUS_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_o <= '0;
        else begin
            if (state == S_IDLE && |req && oor_in) err_o[ERR_OOR] <= 1'b1;
            for (int p = 0; p < N_PORTS; p++)
                if (rw_i[2*p +: 2] == 2'b11) err_o[ERR_ILL] <= 1'b1;
            if (state != S_IDLE && (rw_i[2*own +: 2] != lat_rw || addr_i[ADDR_W*own +: ADDR_W] != lat_addr))
                err_o[ERR_CHG] <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed vector bench for mem_bus_arb (2 ports, latency 4, 1024 words).
module tb_mem_bus_arb;
    localparam int NP = 2, AW = 16, DW = 16, MW = 1024, LAT = 4;
`ifdef MEMBUS_ERR_EN
    localparam logic [15:0] OOR_EXP = 16'h0000;
`else
    localparam logic [15:0] OOR_EXP = 16'h5A5A;
`endif

    logic clk = 1'b0, reset = 1'b0;
    logic [2*NP-1:0] rw_i = '0;
    logic [AW*NP-1:0] addr_i = '0;
    logic [DW*NP-1:0] wdata_i = '0;
    logic [DW*NP-1:0] rdata_o;
    logic [NP-1:0] ack_o, gnt_o;
    logic busy_o;
`ifdef MEMBUS_ERR_EN
    logic [3:0] err_o;
`endif
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_bus_arb #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .rw_i    (rw_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .ack_o   (ack_o),
        .gnt_o   (gnt_o),
`ifdef MEMBUS_ERR_EN
        .err_o   (err_o),
`endif
        .busy_o  (busy_o)
    );

    typedef struct {
        int          port;
        logic [1:0]  rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int port, input logic [1:0] rw, input logic [15:0] addr, input logic [15:0] wdata);
        rw_i = '0;
        addr_i = '0;
        wdata_i = '0;
        rw_i[2*port +: 2] = rw;
        addr_i[16*port +: 16] = addr;
        wdata_i[16*port +: 16] = wdata;
    endtask

    task automatic reset_dut();
        rw_i = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_txn(input string name, input int port, input logic [1:0] rw,
                          input logic [15:0] addr, input logic [15:0] wdata, input logic [15:0] exp);
        int n;
        drive(port, rw, addr, wdata);
        @(negedge clk);
        check({name, " gnt"}, 64'(gnt_o), 64'(1 << port));
        n = 0;
        while (!ack_o[port] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " ack latency"}, 64'(n), 64'(LAT + 1));
        rw_i = '0;
        if (rw == 2'b01) check({name, " rdata"}, 64'(rdata_o[16*port +: 16]), 64'(exp));
        @(negedge clk);
        check({name, " ack pulse"}, 64'(ack_o), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int prev, k, last_c, n;
        logic seen;
        vecs[0]  = '{0, 2'b10, 16'h0010, 16'hBEEF, 16'h0000};
        vecs[1]  = '{0, 2'b01, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[2]  = '{1, 2'b10, 16'h0020, 16'h1234, 16'h0000};
        vecs[3]  = '{1, 2'b01, 16'h0020, 16'h0000, 16'h1234};
        vecs[4]  = '{0, 2'b01, 16'h0020, 16'h0000, 16'h1234};
        vecs[5]  = '{1, 2'b10, 16'h0010, 16'hCAFE, 16'h0000};
        vecs[6]  = '{0, 2'b01, 16'h0010, 16'h0000, 16'hCAFE};
        vecs[7]  = '{0, 2'b10, 16'h0000, 16'h5A5A, 16'h0000};
        vecs[8]  = '{1, 2'b10, 16'h03FF, 16'h7777, 16'h0000};
        vecs[9]  = '{0, 2'b01, 16'h03FF, 16'h0000, 16'h7777};
        vecs[10] = '{1, 2'b01, 16'h0010, 16'h0000, 16'hCAFE};
        vecs[11] = '{1, 2'b01, 16'h0000, 16'h0000, 16'h5A5A};

        reset_dut();
        check("reset gnt", 64'(gnt_o), 64'(0));
        check("reset ack", 64'(ack_o), 64'(0));
        check("reset busy", 64'(busy_o), 64'(0));
        check("reset rdata", 64'(rdata_o), 64'(0));
`ifdef MEMBUS_ERR_EN
        check("reset err", 64'(err_o), 64'(0));
`endif

        for (int i = 0; i < 12; i++)
            do_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        check("rdata0 held", 64'(rdata_o[15:0]), 64'(16'h7777));

        // Both ports hold RD from reset: grants must alternate 0,1,0,1 at LAT+2 spacing.
        reset_dut();
        check("rdata cleared", 64'(rdata_o), 64'(0));
        rw_i = 4'b0101;
        addr_i = {16'h0020, 16'h0010};
        prev = 0;
        k = 0;
        last_c = 0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            @(negedge clk);
            check($sformatf("busy vs gnt c%0d", c), 64'(busy_o), 64'(|gnt_o));
            if (gnt_o != '0 && prev == 0) begin
                check($sformatf("rr grant %0d", k), 64'(gnt_o), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
                if (k > 0) check($sformatf("rr spacing %0d", k), 64'(c - last_c), 64'(LAT + 2));
                last_c = c;
                k++;
            end
            prev = int'(gnt_o);
        end
        check("rr grant count", 64'(k), 64'(4));
        rw_i[1:0] = 2'b00;
        n = 0;
        while (!ack_o[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        rw_i = '0;
        check("rr ack1 seen", 64'(ack_o[1]), 64'(1));
        check("rr rdata0", 64'(rdata_o[15:0]), 64'(16'hCAFE));
        check("rr rdata1", 64'(rdata_o[31:16]), 64'(16'h1234));
        @(negedge clk);

        // Reset during a port1 write aborts it without touching memory.
        drive(1, 2'b10, 16'h0020, 16'hDEAD);
        @(negedge clk);
        check("abort gnt", 64'(gnt_o), 64'(2'b10));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy", 64'(busy_o), 64'(0));
        check("abort gnt clr", 64'(gnt_o), 64'(0));
        rw_i = '0;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= |ack_o;
        end
        check("abort no ack", 64'(seen), 64'(0));
        do_txn("rd after abort", 0, 2'b01, 16'h0020, 16'h0000, 16'h1234);

        // Illegal rw=11 is never granted.
        drive(1, 2'b11, 16'h0010, 16'h0000);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= busy_o | (|gnt_o) | (|ack_o);
        end
        rw_i = '0;
        check("illegal ignored", 64'(seen), 64'(0));
`ifdef MEMBUS_ERR_EN
        check("illegal err bit", 64'(err_o[1]), 64'(1));
`endif

        // Address past MEM_WORDS: wraps by default, reads 0 with error checking.
        do_txn("oor rd", 0, 2'b01, 16'h0400, 16'h0000, OOR_EXP);
`ifdef MEMBUS_ERR_EN
        check("err final", 64'(err_o), 64'(4'b0011));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
